// File: rtl/gpio_port.sv
// gpio_port: 8-bit memory-mapped GPIO with output register, synchronised inputs,
// rising-edge flags and maskable interrupt. Define GPIO_DEBOUNCE_EN to build the input debouncer.
module gpio_port #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned STABLE_N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  D,
    output logic [7:0]  o,
    output logic        int_o
);

    typedef enum logic [1:0] {
        REG_IN   = 2'd0,
        REG_OUT  = 2'd1,
        REG_EDGE = 2'd2,
        REG_MASK = 2'd3
    } reg_sel_e;

    reg_sel_e   sel;
    logic       wr;
    logic [7:0] sync_q1;
    logic [7:0] sync_q;
    logic [7:0] in_q;
    logic [7:0] in_d;
    logic [7:0] out_q;
    logic [7:0] edge_q;
    logic [7:0] mask_q;
    logic [7:0] w1c;
    logic       unused_ok;

    assign sel = reg_sel_e'(addr[3:2]);
    assign wr  = ce & we;
    assign o   = out_q;
    assign w1c = (wr && sel == REG_EDGE) ? wdata[7:0] : '0;

    // Upper data bits and byte-lane address bits are don't-cares on this bus.
    assign unused_ok = &{1'b0, wdata[31:8], addr[1:0], TICK_DIV == 0, STABLE_N == 0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q  <= '0;
        end else begin
            sync_q1 <= D;
            sync_q  <= sync_q1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [SW-1:0] stab_q [8];
    logic [SW-1:0] stab_d [8];

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // A bit toggles only after STABLE_N consecutive ticks disagree with IN.
    always_comb begin
        in_d = in_q;
        for (int unsigned i = 0; i < 8; i++) begin
            stab_d[i] = stab_q[i];
            if (tick) begin
                if (sync_q[i] != in_q[i]) begin
                    if (stab_q[i] == SW'(STABLE_N - 1)) begin
                        in_d[i]   = ~in_q[i];
                        stab_d[i] = '0;
                    end else begin
                        stab_d[i] = stab_q[i] + SW'(1);
                    end
                end else begin
                    stab_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                stab_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                stab_q[i] <= stab_d[i];
            end
        end
    end
`else
    assign in_d = sync_q;
`endif

    // Rising edges are flagged on the same edge IN updates; set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q   <= '0;
            out_q  <= '0;
            edge_q <= '0;
            mask_q <= '0;
            int_o  <= 1'b0;
        end else begin
            in_q   <= in_d;
            edge_q <= (edge_q & ~w1c) | (in_d & ~in_q);
            int_o  <= |(edge_q & mask_q);
            if (wr && sel == REG_OUT) begin
                out_q <= wdata[7:0];
            end
            if (wr && sel == REG_MASK) begin
                mask_q <= wdata[7:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (ce && !we) begin
            case (sel)
                REG_IN:   rdata[7:0] = in_q;
                REG_OUT:  rdata[7:0] = out_q;
                REG_EDGE: rdata[7:0] = edge_q;
                REG_MASK: rdata[7:0] = mask_q;
                default:  rdata      = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_port.sv
// Directed self-checking bench for gpio_port (TICK_DIV=4, STABLE_N=3).
// Covers both builds; debounce-specific vectors follow GPIO_DEBOUNCE_EN.
module tb_gpio_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  D;
    logic [7:0]  o;
    logic        int_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;

    gpio_port #(.TICK_DIV(4), .STABLE_N(3)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .D(D), .o(o), .int_o(int_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        ce = 1'b0; addr = '0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bit          found;
        int unsigned lat;
        int unsigned t_ref;
        int unsigned t0;

        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; D = '0;
        repeat (3) @(negedge clk);
        check("rst_o", {24'b0, o}, 32'h0);
        check("rst_int", {31'b0, int_o}, 32'h0);
        rd(4'h0, r); check("rst_in", r, 32'h0);
        rd(4'h4, r); check("rst_out", r, 32'h0);
        rd(4'h8, r); check("rst_edge", r, 32'h0);
        rd(4'hC, r); check("rst_mask", r, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        wr(4'h4, 32'h0000_00A5);
        check("out_pin", {24'b0, o}, 32'hA5);
        rd(4'h4, r); check("out_read", r, 32'h0000_00A5);
        addr = 4'h4;
        #1;
        check("idle_rdata", rdata, 32'h0);
        wr(4'h0, 32'hFFFF_FFFF);
        rd(4'h0, r); check("in_readonly", r, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_o", {24'b0, o}, 32'h0);
        rd(4'h4, r); check("midrst_out", r, 32'h0);
        @(negedge clk);
        rst = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
        D = 8'h01;
        found = 1'b0; lat = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(negedge clk);
            rd(4'h0, r);
            if (r[7:0] == 8'h01) begin found = 1'b1; lat = k; end
        end
        check("db_settle", {31'b0, found}, 32'h1);
        check("db_latency_le14", {31'b0, lat <= 14}, 32'h1);
        rd(4'h8, r); check("db_edge", r, 32'h01);
        check("db_int_unmasked", {31'b0, int_o}, 32'h0);
        wr(4'h8, 32'h01);
        rd(4'h8, r); check("db_w1c", r, 32'h0);

        wr(4'hC, 32'h08);
        @(negedge clk);
        D = 8'h09;
        repeat (5) @(negedge clk);
        D = 8'h01;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (int_o) found = 1'b1;
        end
        rd(4'h0, r); check("glitch_in", r, 32'h01);
        rd(4'h8, r); check("glitch_edge", r, 32'h0);
        check("glitch_int", {31'b0, found}, 32'h0);

        D = 8'h00;
        repeat (20) @(negedge clk);
        rd(4'h0, r); check("fall_in", r, 32'h0);
        rd(4'h8, r); check("fall_no_edge", r, 32'h0);

        wr(4'hC, 32'h01);
        rd(4'hC, r); check("mask_read", r, 32'h01);
        D = 8'h01;
        found = 1'b0; t_ref = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            rd(4'h8, r);
            if (r[0]) begin found = 1'b1; t_ref = cyc; end
        end
        check("irq_edge_seen", {31'b0, found}, 32'h1);
        check("irq_not_yet", {31'b0, int_o}, 32'h0);
        @(negedge clk);
        check("irq_assert", {31'b0, int_o}, 32'h1);
        wr(4'h8, 32'h01);
        rd(4'h8, r); check("irq_w1c_edge", r, 32'h0);
        check("irq_still_high", {31'b0, int_o}, 32'h1);
        @(negedge clk);
        check("irq_deassert", {31'b0, int_o}, 32'h0);

        // Align to a tick edge: IN[0] rose on one, ticks recur every 4 cycles.
        for (int k = 0; k < 4 && ((cyc - t_ref) % 4) != 0; k++) @(negedge clk);
        check("tick_aligned", (cyc - t_ref) % 4, 32'h0);
        D = 8'h05;
        t0 = cyc;
        repeat (11) @(negedge clk);
        rd(4'h0, r); check("race_pre_in", r, 32'h01);
        ce = 1'b1; we = 1'b1; addr = 4'h8; wdata = 32'h04;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; wdata = '0;
        check("race_cycle", cyc - t0, 32'd12);
        rd(4'h0, r); check("race_in", r, 32'h05);
        rd(4'h8, r); check("race_edge_set_wins", r, 32'h04);
`else
        @(negedge clk);
        D = 8'hF0;
        @(negedge clk);
        @(negedge clk);
        rd(4'h0, r); check("nd_in_2cyc", r, 32'h0);
        @(negedge clk);
        rd(4'h0, r); check("nd_in_3cyc", r, 32'hF0);
        rd(4'h8, r); check("nd_edge", r, 32'hF0);
        check("nd_int_unmasked", {31'b0, int_o}, 32'h0);
        wr(4'h8, 32'hFF);
        rd(4'h8, r); check("nd_w1c", r, 32'h0);

        wr(4'hC, 32'h08);
        @(negedge clk);
        D = 8'hF8;
        repeat (5) @(negedge clk);
        D = 8'hF0;
        repeat (5) @(negedge clk);
        rd(4'h0, r); check("nd_pulse_in", r, 32'hF0);
        rd(4'h8, r); check("nd_pulse_edge", r, 32'h08);
        check("nd_pulse_int", {31'b0, int_o}, 32'h1);
        wr(4'h8, 32'h08);
        @(negedge clk);
        check("nd_pulse_int_clr", {31'b0, int_o}, 32'h0);

        wr(4'hC, 32'h01);
        rd(4'hC, r); check("mask_read", r, 32'h01);
        @(negedge clk);
        D = 8'hF1;
        repeat (3) @(negedge clk);
        rd(4'h8, r); check("irq_edge", r, 32'h01);
        check("irq_not_yet", {31'b0, int_o}, 32'h0);
        @(negedge clk);
        check("irq_assert", {31'b0, int_o}, 32'h1);
        wr(4'h8, 32'h01);
        rd(4'h8, r); check("irq_w1c_edge", r, 32'h0);
        check("irq_still_high", {31'b0, int_o}, 32'h1);
        @(negedge clk);
        check("irq_deassert", {31'b0, int_o}, 32'h0);

        @(negedge clk);
        D = 8'hF5;
        @(negedge clk);
        @(negedge clk);
        rd(4'h0, r); check("race_pre_in", r, 32'hF1);
        ce = 1'b1; we = 1'b1; addr = 4'h8; wdata = 32'h04;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; wdata = '0;
        rd(4'h0, r); check("race_in", r, 32'hF5);
        rd(4'h8, r); check("race_edge_set_wins", r, 32'h04);
`endif

        @(negedge clk);
        rst = 1'b1;
        #1;
        rd(4'h0, r); check("rst2_in", r, 32'h0);
        rd(4'h8, r); check("rst2_edge", r, 32'h0);
        rd(4'hC, r); check("rst2_mask", r, 32'h0);
        check("rst2_int", {31'b0, int_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            rd(4'h0, r);
            if (r == {24'b0, D}) found = 1'b1;
        end
        check("rst2_resettle", {31'b0, found}, 32'h1);
        rd(4'h8, r); check("rst2_edge_held", r, {24'b0, D});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
